// File: rtl/frame_pkg.sv
// frame_pkg: state encodings and framing constants shared by the frame sender blocks
package frame_pkg;
    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, REQ, WAIT_S, SEND_HI, SEND_LO, CHK, DONE, WAIT_SWAP
    } state_t;
    typedef enum logic {E_IDLE, E_GAP} emit_state_t;
    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;
    localparam int CHK_W = 8;
endpackage

// File: rtl/uart_byte_emitter.sv
// uart_byte_emitter: hands one byte to the serial interface, then skips a cycle so a fresh tx_busy is seen
module uart_byte_emitter
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_start,
    input  logic       i_tx_busy,
    output logic       o_done,
    output logic [7:0] o_tx_data,
    output logic       o_new_tx_data
);
    emit_state_t r_state, w_next;
    logic [7:0] r_tx_data;
    logic r_new;
    logic w_fire;
    always_comb begin
        w_fire = r_state == E_IDLE && i_start && !i_tx_busy;
        w_next = w_fire ? E_GAP : E_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= E_IDLE;
            r_tx_data <= '0;
            r_new <= 1'b0;
        end else begin
            r_state <= w_next;
            r_new <= w_fire;
            if (w_fire) r_tx_data <= i_byte;
        end
    end
    assign o_done = r_state == E_GAP;
    assign o_tx_data = r_tx_data;
    assign o_new_tx_data = r_new;
endmodule

// File: rtl/frame_uart_sender.sv
// frame_uart_sender: pulls samples from the frame store and sends sync, sample bytes and checksum over the UART
module frame_uart_sender
    import frame_pkg::*;
#(
    parameter logic [7:0] SYNC0 = SYNC0_DEF,
    parameter logic [7:0] SYNC1 = SYNC1_DEF,
    parameter int DATA_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        new_sample_in,
    input  logic        frame_end_in,
    output logic        read_ready,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic        busy,
    output logic [15:0] frames_sent
);
    state_t r_state, w_next;
    logic [15:0] r_sample;
    logic [CHK_W-1:0] r_chk;
    logic r_last, r_got, r_read_ready, r_busy;
    logic [1:0] r_dly;
    logic [15:0] r_frames;
    logic w_start, w_done, w_strobe, w_capture;
    logic [7:0] w_byte;
    uart_byte_emitter u_emit (
        .clk(clk), .rst(rst), .i_byte(w_byte), .i_start(w_start), .i_tx_busy(tx_busy),
        .o_done(w_done), .o_tx_data(tx_data), .o_new_tx_data(new_tx_data)
    );
    always_comb begin
        w_strobe = r_state == WAIT_S && !r_got && new_sample_in;
        w_capture = r_state == WAIT_S && ((DATA_DELAY == 0) ? w_strobe : (r_got && r_dly == 2'd0));
        w_start = r_state inside {HDR0, HDR1, SEND_HI, SEND_LO, CHK};
        w_byte = r_state == HDR0 ? SYNC0 : r_state == HDR1 ? SYNC1 :
                 r_state == SEND_HI ? r_sample[15:8] : r_state == SEND_LO ? r_sample[7:0] : r_chk;
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = frame_end_in ? IDLE : HDR0;
            HDR0:      w_next = w_done ? HDR1 : HDR0;
            HDR1:      w_next = w_done ? REQ : HDR1;
            REQ:       w_next = WAIT_S;
            WAIT_S:    w_next = w_capture ? SEND_HI : WAIT_S;
            SEND_HI:   w_next = w_done ? SEND_LO : SEND_HI;
            SEND_LO:   w_next = w_done ? (r_last ? CHK : REQ) : SEND_LO;
            CHK:       w_next = w_done ? DONE : CHK;
            DONE:      w_next = WAIT_SWAP;
            WAIT_SWAP: w_next = frame_end_in ? WAIT_SWAP : IDLE;
            default:   w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sample <= '0;
            r_chk <= '0;
            r_last <= 1'b0;
            r_got <= 1'b0;
            r_dly <= '0;
            r_read_ready <= 1'b0;
            r_busy <= 1'b0;
            r_frames <= '0;
        end else begin
            r_state <= w_next;
            r_read_ready <= w_next == REQ;
            r_busy <= w_next inside {HDR0, HDR1, REQ, WAIT_S, SEND_HI, SEND_LO, CHK};
            if (r_state == IDLE) r_chk <= '0;
            if (w_done && r_state inside {SEND_HI, SEND_LO}) r_chk <= r_chk + w_byte;
            // Strobe starts the DATA_DELAY countdown; the last-sample flag travels with the strobe
            if (w_strobe) begin
                r_last <= frame_end_in;
                r_got <= DATA_DELAY != 0;
                r_dly <= 2'(DATA_DELAY - 1);
            end else if (r_got && r_dly != 2'd0) begin
                r_dly <= r_dly - 2'd1;
            end
            if (w_capture) begin
                r_sample <= sample_in;
                r_got <= 1'b0;
            end
            if (r_state == DONE) r_frames <= r_frames + 16'd1;
        end
    end
    assign read_ready = r_read_ready;
    assign busy = r_busy;
    assign frames_sent = r_frames;
endmodule
